branch_cmp_unit: RTL
====================

// Module: branch_cmp_unit
// PURPOSE
//   Parametrised, registered branch/compare unit for the pipelined MIPS core. One decoded
//   op selects the condition; result is held in one output register stage with a
//   valid/ready handshake, stall hold and flush. Sits at the ID/EX boundary, feeding
//   branch resolution, set-on-less-than writeback and conditional-link (bioal-style)
//   overflow checks.
// PARAMETERS
//   WIDTH   32  operand width in bits (>=2)
//   TAG_W   5   width of sideband tag carried with each op (e.g. dest reg)
//   CNT_W   16  statistics counter width (used only with CMP_STATS_EN)
// PORTS
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous, active-high reset
//   in_valid     in   1       request present
//   in_ready     out  1       unit can accept this cycle
//   in_op        in   4       cmp_pkg::cmp_op_e
//   in_a         in   WIDTH   operand A (rs)
//   in_b         in   WIDTH   operand B (rt)
//   in_tag       in   TAG_W   sideband, passed through unchanged
//   flush        in   1       kill held result and any same-cycle capture
//   out_valid    out  1       result register holds a live result
//   out_ready    in   1       consumer takes result this cycle
//   out_cond     out  1       selected condition true
//   out_ovf      out  1       signed overflow of A+B (independent of op)
//   out_illegal  out  1       op code not defined
//   out_tag      out  TAG_W   captured in_tag
//   stat_total   out  CNT_W   (CMP_STATS_EN) ops accepted
//   stat_taken   out  CNT_W   (CMP_STATS_EN) accepted ops with cond=1
// BEHAVIOUR
//   - One clock, synchronous active-high reset. Reset: out_valid=0, out_cond=0, out_ovf=0,
//     out_illegal=0, out_tag=0, stat_*=0.
//   - Ops: 0 EQ a==b; 1 NE; 2 LEZ a<=0 signed; 3 GTZ a>0; 4 LTZ a<0; 5 GEZ a>=0;
//     6 SLT a<b signed; 7 SLTU a<b unsigned; 8 OVF cond=out_ovf; 9-15 cond=0, illegal=1.
//   - Overflow: sign-extend both to WIDTH+1, add; ovf = sum[WIDTH]^sum[WIDTH-1].
//   - in_ready = !out_valid | out_ready (combinational; no skid buffer).
//   - Capture when in_valid & in_ready & !flush: all out_* loaded next edge, out_valid=1.
//     Latency exactly 1 cycle; back-to-back throughput 1/cycle while out_ready=1.
//   - Stall (out_valid & !out_ready): all out_* held stable, in_ready=0.
//   - Pop without new capture: out_valid->0; data regs keep last value.
//   - flush: out_valid->0 next edge; same-cycle request dropped, not counted. flush beats
//     capture; reset beats flush. Reset mid-stall discards held result.
//   - Outputs only from registers; no combinational in->out path except in_ready.
// CONFIGURATION
//   CMP_STATS_EN defined: stat_total/stat_taken increment on each non-flushed capture,
//     saturate at all-ones, cleared only by reset.
//   Not defined: stat ports tied to 0, no counter flops.
// STRUCTURE
//   cmp_pkg: cmp_op_e enum (4-bit codes above), CMP_OP_W=4, OP_LAST_LEGAL=8.
//   Sub-module cmp_core: purely combinational (op,a,b)->(cond,ovf,illegal), WIDTH param;
//   branch_cmp_unit owns handshake, output register and stats.
// TESTING
//   1 reset held 2 cycles, in_valid=1 -> out_valid=0, in_ready=1, stat_*=0 throughout.
//   2 WIDTH=32: EQ a=b=5 ->cond=1; SLT a=-1,b=1 ->cond=1; SLTU same ->cond=0;
//     GTZ a=0 ->0; LEZ a=0x80000000 ->1; all 1 cycle after accept.
//   3 OVF a=0x7FFFFFFF,b=1 ->cond=1,ovf=1; a=-1,b=1 ->ovf=0; op=12 ->illegal=1,cond=0.
//   4 out_ready=0 for 3 cycles with new in_valid -> in_ready=0, out_* unchanged, then
//     out_ready=1 -> next op appears following cycle, no loss/duplication.
//   5 flush with held result and in_valid=1 -> out_valid=0 next cycle, stat_total
//     unchanged; flush+reset same cycle -> reset values.
//   6 CMP_STATS_EN, CNT_W=4: 20 taken ops -> stat_total=stat_taken=15 (saturated).

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the branch/compare unit: op encoding and op-field width.
package cmp_pkg;

  localparam int CMP_OP_W = 4;

  typedef enum logic [CMP_OP_W-1:0] {
    OP_EQ   = 4'd0,
    OP_NE   = 4'd1,
    OP_LEZ  = 4'd2,
    OP_GTZ  = 4'd3,
    OP_LTZ  = 4'd4,
    OP_GEZ  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_OVF  = 4'd8
  } cmp_op_e;

  // Highest defined code; everything above it is reported as illegal.
  localparam logic [CMP_OP_W-1:0] OP_LAST_LEGAL = 4'd8;

endpackage : cmp_pkg

// File: rtl/branch_cmp_unit_if.sv
// Request/result bundle of the branch/compare unit.
// master = the pipeline side (drives requests, consumes results), slave = the unit.
interface branch_cmp_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
);
  import cmp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  cmp_op_e          in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_cond;
  logic             out_ovf;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] stat_total;
  logic [CNT_W-1:0] stat_taken;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_cond, out_ovf, out_illegal, out_tag,
           stat_total, stat_taken
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    output in_ready, out_valid, out_cond, out_ovf, out_illegal, out_tag,
           stat_total, stat_taken
  );

endinterface : branch_cmp_unit_if

// File: rtl/branch_cmp_unit_core.sv
// cmp_core: purely combinational condition evaluation (op, a, b) -> (cond, ovf, illegal).
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  cmp_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cond,
  output logic             ovf,
  output logic             illegal
);

  logic [WIDTH:0] sum;
  logic           aNeg;
  logic           aZero;

  // Overflow is judged on a one-bit-wider signed sum, independent of the op.
  assign sum   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign ovf   = sum[WIDTH] ^ sum[WIDTH-1];
  assign aNeg  = a[WIDTH-1];
  assign aZero = (a == '0);

  // Select the condition for the decoded op; undefined codes give cond=0, illegal=1.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_EQ:   cond = (a == b);
      OP_NE:   cond = (a != b);
      OP_LEZ:  cond = aNeg | aZero;
      OP_GTZ:  cond = !aNeg & !aZero;
      OP_LTZ:  cond = aNeg;
      OP_GEZ:  cond = !aNeg;
      OP_SLT:  cond = ($signed(a) < $signed(b));
      OP_SLTU: cond = (a < b);
      OP_OVF:  cond = ovf;
      default: illegal = 1'b1;
    endcase
  end

endmodule : cmp_core

// File: rtl/branch_cmp_unit.sv
// branch_cmp_unit: registered branch/compare stage with valid/ready, stall hold and flush.
// Optional feature macro: CMP_STATS_EN (saturating accepted/taken counters).
module branch_cmp_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  branch_cmp_unit_if.slave  bus
);

  logic             coreCond;
  logic             coreOvf;
  logic             coreIllegal;
  logic             outValidQ;
  logic             outCondQ;
  logic             outOvfQ;
  logic             outIllegalQ;
  logic [TAG_W-1:0] outTagQ;
  logic             inReady;
  logic             capture;

  cmp_core #(.WIDTH(WIDTH)) core (
    .op      (bus.in_op),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .cond    (coreCond),
    .ovf     (coreOvf),
    .illegal (coreIllegal)
  );

  assign inReady = !outValidQ || bus.out_ready;
  assign capture = bus.in_valid && inReady && !bus.flush;

  // Output register: reset beats flush, flush beats capture, a pop only clears valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValidQ   <= 1'b0;
      outCondQ    <= 1'b0;
      outOvfQ     <= 1'b0;
      outIllegalQ <= 1'b0;
      outTagQ     <= '0;
    end else if (bus.flush) begin
      outValidQ <= 1'b0;
    end else if (capture) begin
      outValidQ   <= 1'b1;
      outCondQ    <= coreCond;
      outOvfQ     <= coreOvf;
      outIllegalQ <= coreIllegal;
      outTagQ     <= bus.in_tag;
    end else if (bus.out_ready) begin
      outValidQ <= 1'b0;
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.out_valid   = outValidQ;
  assign bus.out_cond    = outCondQ;
  assign bus.out_ovf     = outOvfQ;
  assign bus.out_illegal = outIllegalQ;
  assign bus.out_tag     = outTagQ;

`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] statTotalQ;
  logic [CNT_W-1:0] statTakenQ;

  // Saturating counters of accepted ops and of accepted ops whose condition held.
  always_ff @(posedge clk) begin
    if (reset) begin
      statTotalQ <= '0;
      statTakenQ <= '0;
    end else if (capture) begin
      if (statTotalQ != {CNT_W{1'b1}}) statTotalQ <= statTotalQ + CNT_W'(1);
      if (coreCond && (statTakenQ != {CNT_W{1'b1}})) statTakenQ <= statTakenQ + CNT_W'(1);
    end
  end

  assign bus.stat_total = statTotalQ;
  assign bus.stat_taken = statTakenQ;
`else
  assign bus.stat_total = {CNT_W{1'b0}};
  assign bus.stat_taken = {CNT_W{1'b0}};
`endif

endmodule : branch_cmp_unit
